// File: rtl/des_pkg.sv
// Shared DES definitions: block/half widths, the IP/FP wire-reorder tables and the
// slot type carried through the init-stage buffering.
package des_pkg;

    localparam int DES_BLK_W  = 64;
    localparam int DES_HALF_W = 32;

    typedef logic [DES_HALF_W-1:0] des_half_t;
    typedef logic [DES_BLK_W-1:0]  des_blk_t;

    // One buffered block: permuted text plus the mode bit that travels with it.
    typedef struct packed {
        des_blk_t ip;
        logic     decrypt;
    } des_slot_t;

    // Entry i names the 1-based DES source bit for output bit i.
    localparam int IP_TABLE [DES_BLK_W] = '{
        58, 50, 42, 34, 26, 18, 10,  2,
        60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6,
        64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1,
        59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5,
        63, 55, 47, 39, 31, 23, 15,  7
    };

    // Inverse of IP_TABLE, used by the final permutation stage.
    localparam int FP_TABLE [DES_BLK_W] = '{
        40,  8, 48, 16, 56, 24, 64, 32,
        39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30,
        37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28,
        35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26,
        33,  1, 41,  9, 49, 17, 57, 25
    };

endpackage

// File: rtl/init_perm.sv
// DES initial permutation: a pure combinational wire reorder generated from IP_TABLE.
module init_perm
    import des_pkg::*;
(
    input  logic [DES_BLK_W-1:0] in,
    output logic [DES_BLK_W-1:0] out
);

    for (genvar i = 0; i < DES_BLK_W; i++) begin : g_bit
        localparam logic [5:0] SRC = 6'(IP_TABLE[i] - 1);
        assign out[i] = in[SRC];
    end

endmodule

// File: rtl/des_init_stage.sv
// DES input stage: initial permutation followed by an output register plus one skid
// register, giving full throughput with in_ready driven purely from state.
module des_init_stage
    import des_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DES_BLK_W-1:0] in_text,
    input  logic                 in_decrypt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output des_half_t            out_l,
    output des_half_t            out_r,
    output logic                 out_decrypt,
    output logic [CNT_W-1:0]     blk_cnt
);

    des_blk_t  ip_in;
    des_slot_t or_q;
    des_slot_t sk_q;
    logic      or_vld;
    logic      sk_vld;
    logic      accept;
    logic      pop;

    init_perm u_perm (
        .in  (in_text),
        .out (ip_in)
    );

    // Occupancy is {sk_vld, or_vld}: 00 EMPTY, 01 ONE, 11 FULL.
    assign accept = in_valid && !sk_vld;
    assign pop    = or_vld && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            or_q    <= '0;
            sk_q    <= '0;
            or_vld  <= 1'b0;
            sk_vld  <= 1'b0;
            blk_cnt <= '0;
        end else begin
            if (!or_vld || pop) begin
                // Output register frees up: refill from skid first to keep arrival order.
                or_vld <= sk_vld || accept;
                if (sk_vld) begin
                    or_q   <= sk_q;
                    sk_vld <= 1'b0;
                end else if (accept) begin
                    or_q <= '{ip: ip_in, decrypt: in_decrypt};
                end
            end else if (accept) begin
                sk_q   <= '{ip: ip_in, decrypt: in_decrypt};
                sk_vld <= 1'b1;
            end
            if (accept) begin
                blk_cnt <= blk_cnt + 1'b1;
            end
        end
    end

    assign in_ready    = !sk_vld;
    assign out_valid   = or_vld;
    assign out_l       = or_q.ip[DES_HALF_W-1:0];
    assign out_r       = or_q.ip[DES_BLK_W-1:DES_HALF_W];
    assign out_decrypt = or_q.decrypt;

endmodule

// File: tb/tb_des_init_stage.sv
// Self-checking bench for des_init_stage: directed steps plus a scoreboard of expected
// permuted blocks, with an independent IP/FP model.
module tb_des_init_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_text = '0;
    logic        in_decrypt = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_l;
    logic [31:0] out_r;
    logic        out_decrypt;
    logic [15:0] blk_cnt;

    logic        in_ready4;
    logic        out_valid4;
    logic [31:0] out_l4;
    logic [31:0] out_r4;
    logic        out_decrypt4;
    logic [3:0]  blk_cnt4;

    always #5 clk = ~clk;

    des_init_stage #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_text(in_text), .in_decrypt(in_decrypt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_l(out_l), .out_r(out_r), .out_decrypt(out_decrypt),
        .blk_cnt(blk_cnt)
    );

    des_init_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready4),
        .in_text(in_text), .in_decrypt(in_decrypt),
        .out_valid(out_valid4), .out_ready(out_ready),
        .out_l(out_l4), .out_r(out_r4), .out_decrypt(out_decrypt4),
        .blk_cnt(blk_cnt4)
    );

    int ip_tab [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7
    };
    int fp_tab [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25
    };

    typedef struct {
        logic [63:0] ip;
        logic        dec;
        logic [63:0] txt;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   accs  = 0;

    function automatic logic [63:0] ip_model(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = x[ip_tab[i] - 1];
        return r;
    endfunction

    function automatic logic [63:0] fp_model(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = x[fp_tab[i] - 1];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge with inputs driven; observes the handshake, then advances one clock.
    task automatic cycle();
        logic acc;
        logic pop;
        exp_t e;
        #1;
        acc = in_valid && in_ready;
        pop = out_valid && out_ready;
        if (acc) begin
            sb.push_back('{ip: ip_model(in_text), dec: in_decrypt, txt: in_text});
            accs++;
        end
        if (pop) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_out_l", {32'd0, out_l}, {32'd0, e.ip[31:0]});
                chk("sb_out_r", {32'd0, out_r}, {32'd0, e.ip[63:32]});
                chk("sb_out_decrypt", {63'd0, out_decrypt}, {63'd0, e.dec});
                chk("sb_fp_roundtrip", fp_model({out_r, out_l}), e.txt);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        sb.delete();
        accs = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] hold_l;
        logic [31:0] hold_r;
        int          cyc;

        // Reset state
        #2;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_blk_cnt", {48'd0, blk_cnt}, 64'd0);
        chk("rst_out_l", {32'd0, out_l}, 64'd0);
        chk("rst_out_r", {32'd0, out_r}, 64'd0);
        chk("rst_out_decrypt", {63'd0, out_decrypt}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Test 1: DES bit 58 lands in L0 bit 0 one clock after accept
        in_text = 64'h0200_0000_0000_0000; in_decrypt = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        #1;
        chk("t1_out_valid", {63'd0, out_valid}, 64'd1);
        chk("t1_out_l", {32'd0, out_l}, 64'h1);
        chk("t1_out_r", {32'd0, out_r}, 64'h0);

        // Test 2: DES bit 1 lands in R0 bit 7, mode bit follows
        in_text = 64'h1; in_decrypt = 1'b1;
        cycle();
        #1;
        chk("t2_out_l", {32'd0, out_l}, 64'h0);
        chk("t2_out_r", {32'd0, out_r}, 64'h80);
        chk("t2_out_decrypt", {63'd0, out_decrypt}, 64'd1);
        in_valid = 1'b0; in_decrypt = 1'b0;
        cycle();
        chk("t2_blk_cnt", {48'd0, blk_cnt}, 64'd2);
        chk("t2_empty", {63'd0, out_valid}, 64'd0);

        // Test 4: backpressure with three offered blocks
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_text = {$urandom, $urandom}; in_decrypt = k[0]; in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        #1;
        chk("bp_accepts", {48'd0, blk_cnt}, 64'd4);
        chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_front_l", {32'd0, out_l}, {32'd0, sb[0].ip[31:0]});
        hold_l = out_l; hold_r = out_r;
        cycle();
        cycle();
        chk("bp_stable", {out_r, out_l}, {hold_r, hold_l});
        out_ready = 1'b1;
        cycle();
        chk("bp_second_next", {63'd0, out_valid}, 64'd1);
        chk("bp_in_ready_back", {63'd0, in_ready}, 64'd1);
        cycle();
        chk("bp_drained", {63'd0, out_valid}, 64'd0);
        chk("bp_sb_empty", 64'(sb.size()), 64'd0);

        // Test 3: random traffic, in-order delivery and accept count
        cyc = 0;
        in_text = {$urandom, $urandom}; in_decrypt = 1'($urandom);
        while (accs < 10004 && cyc < 60000) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            if (in_valid && in_ready) begin
                cycle();
                in_text = {$urandom, $urandom}; in_decrypt = 1'($urandom);
            end else begin
                cycle();
            end
            cyc++;
        end
        chk("rand_budget", {63'd0, cyc < 60000}, 64'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        cyc = 0;
        while (sb.size() != 0 && cyc < 10) begin
            cycle();
            cyc++;
        end
        chk("rand_sb_empty", 64'(sb.size()), 64'd0);
        chk("rand_blk_cnt", {48'd0, blk_cnt}, {48'd0, 16'(accs)});

        // Test 5: asynchronous reset while FULL
        out_ready = 1'b0; in_valid = 1'b1;
        in_text = 64'hDEAD_BEEF_0123_4567; in_decrypt = 1'b1;
        cycle();
        cycle();
        chk("full_in_ready", {63'd0, in_ready}, 64'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_blk_cnt", {48'd0, blk_cnt}, 64'd0);
        chk("mid_rst_out_lr", {out_r, out_l}, 64'd0);
        chk("mid_rst_out_decrypt", {63'd0, out_decrypt}, 64'd0);
        sb.delete(); accs = 0; in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("post_rst_out_valid", {63'd0, out_valid}, 64'd0);

        // Test 6: counter wrap with CNT_W=4
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            in_text = {$urandom, $urandom}; in_decrypt = 1'($urandom); in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        chk("wrap_blk_cnt4", {60'd0, blk_cnt4}, 64'd1);
        chk("wrap_blk_cnt16", {48'd0, blk_cnt}, 64'd17);
        chk("wrap_sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
